// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, halt encoding, fetch states and decode field positions
package cpu_pkg;

  localparam int          DEF_ADDR_W    = 16;
  localparam int          DEF_DATA_W    = 32;
  localparam logic [31:0] DEF_HALT_INSN = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  // Field split used by decode (register bank / ALU / memory_control)
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RD_MSB     = 25;
  localparam int RD_LSB     = 21;
  localparam int RS1_MSB    = 20;
  localparam int RS1_LSB    = 16;
  localparam int RS2_MSB    = 15;
  localparam int RS2_LSB    = 11;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  function automatic logic [5:0] opcode_of(input logic [31:0] insn);
    return insn[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/pc_counter.sv
// rtl/pc_counter.sv - fetch address register with load, increment and natural wrap
module pc_counter #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              inc,
  output logic [ADDR_W-1:0] count
);

  // Load wins over increment; increment wraps modulo 2^ADDR_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RESET_PC;
    end else if (load) begin
      count <= load_value;
    end else if (inc) begin
      count <= count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, instruction RAM read sequencing, decode handshake
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                MEM_LAT   = 1,
  parameter logic [DATA_W-1:0] HALT_INSN = DEF_HALT_INSN
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic              Enable,
  output logic              RW_ram,
  output logic [ADDR_W-1:0] Address_in,
  input  logic [DATA_W-1:0] Out,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  fetch_state_t      state, state_next;
  logic [CNT_W-1:0]  lat_cnt, lat_cnt_next;
  logic              capture;
  logic              take_redirect;
  logic              accept;
  logic [ADDR_W-1:0] fetch_pc;

  assign accept        = (state == VALID) && instr_ready;
  assign take_redirect = redirect && (state != HALT);

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_counter (
    .clk        (Clk),
    .rst        (Reset),
    .load       (take_redirect),
    .load_value (redirect_pc),
    .inc        (capture),
    .count      (fetch_pc)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= FETCH;
      lat_cnt     <= '0;
      instruction <= '0;
      pc          <= RESET_PC;
    end else begin
      state   <= state_next;
      lat_cnt <= lat_cnt_next;
      if (capture) begin
        instruction <= Out;
        pc          <= fetch_pc;
      end
    end
  end

  always_comb begin
    state_next   = state;
    lat_cnt_next = lat_cnt;
    capture      = 1'b0;
    case (state)
      FETCH: begin
        state_next   = WAIT;
        lat_cnt_next = CNT_W'(MEM_LAT);
      end
      WAIT: begin
        if (lat_cnt <= CNT_W'(1)) begin
          capture      = 1'b1;
          state_next   = VALID;
          lat_cnt_next = '0;
        end else begin
          lat_cnt_next = lat_cnt - CNT_W'(1);
        end
      end
      VALID: begin
        if (accept) begin
          state_next = (instruction == HALT_INSN) ? HALT : FETCH;
        end
      end
      default: state_next = state;
    endcase
    // Redirect drops any in-flight word and beats the halt transition
    if (take_redirect) begin
      state_next   = FETCH;
      lat_cnt_next = '0;
      capture      = 1'b0;
    end
  end

  // Enable is forced low while reset is held so the first read follows release
  assign Enable      = ~Reset && ((state == FETCH) || (state == WAIT));
  assign RW_ram      = 1'b1;
  assign Address_in  = fetch_pc;
  assign instr_valid = (state == VALID);
  assign halted      = (state == HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        instr_ready = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;

  logic        Enable, RW_ram, instr_valid, halted;
  logic [15:0] Address_in, pc;
  logic [31:0] Out = '0, instruction;

  logic        Enable2, RW_ram2, instr_valid2, halted2;
  logic [15:0] Address_in2, pc2;
  logic [31:0] Out2 = '0, instruction2;

  logic [31:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  instruction_fetch dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .RW_ram(RW_ram), .Address_in(Address_in),
    .Out(Out), .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
  );

  instruction_fetch #(.RESET_PC(16'hFFFF)) dut_wrap (
    .Clk(Clk), .Reset(Reset), .Enable(Enable2), .RW_ram(RW_ram2), .Address_in(Address_in2),
    .Out(Out2), .instruction(instruction2), .instr_valid(instr_valid2), .instr_ready(instr_ready),
    .pc(pc2), .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted2)
  );

  // One-cycle read latency RAM models
  always @(posedge Clk) if (Enable)  Out  <= mem[Address_in];
  always @(posedge Clk) if (Enable2) Out2 <= mem[Address_in2];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    redirect = 1'b0;
    instr_ready = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #3;
    checks++;
    if ({Enable, RW_ram, Address_in, instruction, instr_valid, pc, halted} !==
        {1'b0, 1'b1, 16'h0000, 32'h0, 1'b0, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got E=%b RW=%b A=%h I=%h V=%b pc=%h H=%b, want E=0 RW=1 A=0000 I=0 V=0 pc=0000 H=0",
               Enable, RW_ram, Address_in, instruction, instr_valid, pc, halted);
    end
  endtask

  task automatic test_sequential();
    logic [15:0] n;
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      n = 16'((c - 1) / 3);
      checks++;
      if ((c - 1) % 3 != 2) begin
        if ({Enable, Address_in, instr_valid} !== {1'b1, n, 1'b0}) begin
          errors++;
          $display("FAIL seq_fetch c%0d: got E=%b A=%h V=%b, want E=1 A=%h V=0", c, Enable, Address_in, instr_valid, n);
        end
      end else begin
        if ({Enable, instr_valid, instruction, pc} !== {1'b0, 1'b1, mem[n], n}) begin
          errors++;
          $display("FAIL seq_valid c%0d: got E=%b V=%b I=%h pc=%h, want E=0 V=1 I=%h pc=%h",
                   c, Enable, instr_valid, instruction, pc, mem[n], n);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    instr_ready = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({Enable, instr_valid, instruction, pc} !== {1'b0, 1'b1, 32'h1111_1111, 16'h0000}) begin
        errors++;
        $display("FAIL stall_hold k%0d: got E=%b V=%b I=%h pc=%h, want E=0 V=1 I=11111111 pc=0000",
                 k, Enable, instr_valid, instruction, pc);
      end
      tick();
    end
    instr_ready = 1'b1;
    tick();
    checks++;
    if ({Enable, Address_in, instr_valid} !== {1'b1, 16'h0001, 1'b0}) begin
      errors++;
      $display("FAIL stall_release: got E=%b A=%h V=%b, want E=1 A=0001 V=0", Enable, Address_in, instr_valid);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    tick();
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    checks++;
    if ({Enable, Address_in, instr_valid} !== {1'b1, 16'h0040, 1'b0}) begin
      errors++;
      $display("FAIL redirect_fetch: got E=%b A=%h V=%b, want E=1 A=0040 V=0", Enable, Address_in, instr_valid);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_no_stale: got V=%b, want V=0", instr_valid);
    end
    tick();
    checks++;
    if ({instr_valid, instruction, pc} !== {1'b1, 32'h4040_4040, 16'h0040}) begin
      errors++;
      $display("FAIL redirect_word: got V=%b I=%h pc=%h, want V=1 I=40404040 pc=0040", instr_valid, instruction, pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    checks++;
    if ({Enable2, Address_in2} !== {1'b1, 16'hFFFF}) begin
      errors++;
      $display("FAIL wrap_first_fetch: got E=%b A=%h, want E=1 A=ffff", Enable2, Address_in2);
    end
    tick();
    tick();
    checks++;
    if ({instr_valid2, instruction2, pc2} !== {1'b1, 32'hDEAD_BEEF, 16'hFFFF}) begin
      errors++;
      $display("FAIL wrap_word_ffff: got V=%b I=%h pc=%h, want V=1 I=deadbeef pc=ffff", instr_valid2, instruction2, pc2);
    end
    tick();
    checks++;
    if ({Enable2, Address_in2} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL wrap_to_zero: got E=%b A=%h, want E=1 A=0000", Enable2, Address_in2);
    end
    tick();
    tick();
    checks++;
    if ({instr_valid2, instruction2, pc2} !== {1'b1, 32'h1111_1111, 16'h0000}) begin
      errors++;
      $display("FAIL wrap_word_0000: got V=%b I=%h pc=%h, want V=1 I=11111111 pc=0000", instr_valid2, instruction2, pc2);
    end
  endtask

  task automatic test_halt();
    do_reset();
    for (int k = 0; k < 9; k++) tick();
    checks++;
    if ({Enable, Address_in} !== {1'b1, 16'h0003}) begin
      errors++;
      $display("FAIL halt_fetch3: got E=%b A=%h, want E=1 A=0003", Enable, Address_in);
    end
    tick();
    tick();
    checks++;
    if ({instr_valid, instruction, pc, halted} !== {1'b1, 32'hFFFF_FFFF, 16'h0003, 1'b0}) begin
      errors++;
      $display("FAIL halt_word: got V=%b I=%h pc=%h H=%b, want V=1 I=ffffffff pc=0003 H=0",
               instr_valid, instruction, pc, halted);
    end
    tick();
    checks++;
    if ({halted, Enable, instr_valid} !== 3'b100) begin
      errors++;
      $display("FAIL halt_enter: got H=%b E=%b V=%b, want H=1 E=0 V=0", halted, Enable, instr_valid);
    end
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    tick();
    redirect = 1'b0;
    tick();
    checks++;
    if ({halted, Enable, instr_valid, Address_in} !== {3'b100, 16'h0004}) begin
      errors++;
      $display("FAIL halt_ignores_redirect: got H=%b E=%b V=%b A=%h, want H=1 E=0 V=0 A=0004",
               halted, Enable, instr_valid, Address_in);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if ({Enable, Address_in, instruction, instr_valid, pc, halted} !==
        {1'b0, 16'h0000, 32'h0, 1'b0, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_wait: got E=%b A=%h I=%h V=%b pc=%h H=%b, want E=0 A=0000 I=0 V=0 pc=0000 H=0",
               Enable, Address_in, instruction, instr_valid, pc, halted);
    end
    tick();
    Reset = 1'b0;
    #1;
    checks++;
    if ({Enable, Address_in, instr_valid} !== {1'b1, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_restart: got E=%b A=%h V=%b, want E=1 A=0000 V=0", Enable, Address_in, instr_valid);
    end
    tick();
    tick();
    checks++;
    if ({instr_valid, instruction, pc} !== {1'b1, 32'h1111_1111, 16'h0000}) begin
      errors++;
      $display("FAIL reset_restart_word: got V=%b I=%h pc=%h, want V=1 I=11111111 pc=0000", instr_valid, instruction, pc);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[0]      = 32'h1111_1111;
    mem[1]      = 32'h2222_2222;
    mem[2]      = 32'h3333_3333;
    mem[3]      = 32'hFFFF_FFFF;
    mem[16'h40] = 32'h4040_4040;
    mem[16'hFFFF] = 32'hDEAD_BEEF;

    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid_wait();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
